pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Watches the instruction in ID plus its own shadow copies of EX/MEM destination info.
- Drives the PC and IF/ID write enables, the ID/EX bubble (zeroes all control fields captured by the ID/EX register), the IF/ID flush, and the ID-stage operand forwarding selects.
- Keeps stall and flush performance counters.

Parameters:
BR_FLUSH_CYCLES, 1, cycles of IF/ID flush after a taken branch resolved in ID (1..7)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
Rn_ID  in  5  first source register of instruction in ID
Rm_ID  in  5  second source register (already Reg2Loc-muxed)
uses_Rn_ID  in  1  instruction in ID reads Rn
uses_Rm_ID  in  1  instruction in ID reads Rm
RegWrite_ID  in  1  instruction in ID writes a register
read_enable_ID  in  1  instruction in ID is a load
WriteRegister_ID  in  5  destination of instruction in ID
br_taken_ID  in  1  branch in ID resolved taken this cycle
pc_write  out  1  PC may update
ifid_write  out  1  IF/ID register may capture
ifid_flush  out  1  IF/ID captures a NOP
idex_bubble  out  1  ID/EX captures all-zero controls (RegWrite, MemWrite, read_enable, MemToReg = 0)
fwdA_sel  out  2  Rn operand: 00 regfile, 01 EX ALU result, 10 MEM result
fwdB_sel  out  2  Rm operand, same encoding
stall_count  out  CNT_W  cycles with load-use stall
flush_count  out  CNT_W  cycles with ifid_flush asserted

Behaviour:
- Register X31 (XZR) never creates a hazard or a forward.
- Shadow pipeline registers:
  - EX stage: ex_dst, ex_rw, ex_ld.
  - MEM stage: mem_dst, mem_rw.
- Shadow pipeline update each posedge:
  - mem_* <= ex_*.
  - ex_* <= 0 if idex_bubble, else the *_ID values.
- Match definitions:
  - matchEX(r) = ex_rw & ex_dst==r & r!=31.
  - matchMEM(r) = mem_rw & mem_dst==r & r!=31.
- Load-use hazard (combinational): ld_haz = state==RUN & ex_ld & ((uses_Rn_ID & matchEX(Rn_ID)) | (uses_Rm_ID & matchEX(Rm_ID))).
- Forward select, per operand, only when the uses_* bit is 1:
  - matchEX & !ex_ld -> 01.
  - else matchMEM -> 10.
  - else 00.
  - EX match has priority over MEM match.
- FSM states RUN, FLUSH. 3-bit flush counter fcnt.
- RUN, ld_haz=1:
  - pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
  - br_taken_ID is ignored in this cycle.
  - stall_count++.
  - The next cycle sees ex_ld=0, so the stall is exactly one cycle; forwarding then comes from MEM (10).
- RUN, ld_haz=0, br_taken_ID=1:
  - pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0 (the branch itself proceeds).
  - flush_count++.
  - If BR_FLUSH_CYCLES>1: go to FLUSH with fcnt=BR_FLUSH_CYCLES-1.
- RUN, otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- FLUSH state:
  - The ID instruction is treated as a bubble: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
  - Hazards and br_taken_ID are ignored. fwd selects = 00.
  - flush_count++, fcnt--.
  - Return to RUN when fcnt reaches 1 at a clock edge.
- Reset (synchronous) while reset is high:
  - Outputs forced: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, fwd=00.
  - At the edge: state=RUN, fcnt=0, shadow regs=0, counters=0.
  - The first cycle after reset deasserts: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
  - Reset mid-FLUSH or mid-stall aborts it immediately.
- Counters wrap modulo 2^CNT_W. Counters do not increment while reset is high.
- All non-counter outputs are combinational from state, shadow regs and ID inputs. No added latency.

Test Plan:
- Reset held 2 cycles, then released with all ID inputs 0 -> during reset pc_write=0, idex_bubble=1; after release pc_write=1, ifid_write=1, counters 0.
- LDUR X2 (read_enable_ID=1, RegWrite_ID=1, WriteRegister_ID=2), next ADD reads Rn=2 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1, stall_count=1; following cycle fwdA_sel=10, pc_write=1.
- ADD X3, then SUB reading Rm=3 -> fwdB_sel=01, no stall. One intervening NOP -> fwdB_sel=10. Write to X31 followed by a read of X31 -> fwd 00.
- Back-to-back writes to X5 (EX and MEM both match), then a read of X5 -> fwdA_sel=01 (EX priority).
- BR_FLUSH_CYCLES=3, br_taken_ID=1 in RUN -> ifid_flush=1 for 3 consecutive cycles; idex_bubble=0 in the first, 1 in the next two; flush_count=3; load hazard inputs are ignored during cycles 2-3.
- Load-use and br_taken_ID in the same cycle -> stall only, no flush. Branch re-presented next cycle -> flush. Reset asserted during FLUSH -> state RUN and ifid_flush=0 on the first post-reset cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: hazard/sequencing control for the 5-stage pipeline (load-use stall, branch flush, ID forwarding).
// Latency: all control outputs are combinational from state, shadow regs and ID inputs; counters are registered.
// Backpressure: load-use hazard holds PC and IF/ID for one cycle while a bubble enters ID/EX.
module pipeline_hazard_ctrl #(
    parameter int BR_FLUSH_CYCLES = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rn_ID,
    input  logic [4:0]       Rm_ID,
    input  logic             uses_Rn_ID,
    input  logic             uses_Rm_ID,
    input  logic             RegWrite_ID,
    input  logic             read_enable_ID,
    input  logic [4:0]       WriteRegister_ID,
    input  logic             br_taken_ID,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwdA_sel,
    output logic [1:0]       fwdB_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // fcnt is loaded with the number of flush cycles still owed after the branch cycle itself
    localparam logic [2:0] LP_FCNT_INIT  = 3'(BR_FLUSH_CYCLES - 1);
    localparam bit         LP_MULTI_FLSH = (BR_FLUSH_CYCLES > 1);
    localparam logic [4:0] LP_XZR        = 5'd31;
    localparam logic [1:0] LP_FWD_RF     = 2'b00;
    localparam logic [1:0] LP_FWD_EX     = 2'b01;
    localparam logic [1:0] LP_FWD_MEM    = 2'b10;

    state_t           r_state;
    logic [2:0]       r_fcnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Shadow copies of the destination info held in ID/EX and EX/MEM
    logic [4:0]       r_ex_dst;
    logic             r_ex_rw;
    logic             r_ex_ld;
    logic [4:0]       r_mem_dst;
    logic             r_mem_rw;

    logic             w_mex_rn;
    logic             w_mex_rm;
    logic             w_mmem_rn;
    logic             w_mmem_rm;
    logic             w_ld_haz;
    logic             w_br_go;
    logic             w_flush_now;

    // XZR is hardwired zero, so a write to it never produces a usable result
    assign w_mex_rn  = r_ex_rw  && (r_ex_dst  == Rn_ID) && (Rn_ID != LP_XZR);
    assign w_mex_rm  = r_ex_rw  && (r_ex_dst  == Rm_ID) && (Rm_ID != LP_XZR);
    assign w_mmem_rn = r_mem_rw && (r_mem_dst == Rn_ID) && (Rn_ID != LP_XZR);
    assign w_mmem_rm = r_mem_rw && (r_mem_dst == Rm_ID) && (Rm_ID != LP_XZR);

    // A load in EX cannot forward its data yet, so any consumer in ID must wait one cycle
    assign w_ld_haz    = (r_state == ST_RUN) && r_ex_ld &&
                         ((uses_Rn_ID && w_mex_rn) || (uses_Rm_ID && w_mex_rm));
    // A stall takes precedence: the branch is simply re-presented next cycle
    assign w_br_go     = (r_state == ST_RUN) && !w_ld_haz && br_taken_ID;
    assign w_flush_now = w_br_go || (r_state == ST_FLUSH);

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

    // Pipeline control and forwarding selects, prioritised reset > flush window > stall > branch
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        fwdA_sel    = LP_FWD_RF;
        fwdB_sel    = LP_FWD_RF;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (r_state == ST_FLUSH) begin
            // The instruction in ID is on the wrong path: squash it and keep fetching
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            if (w_ld_haz) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end else if (br_taken_ID) begin
                ifid_flush  = 1'b1;
            end
            // EX holds the youngest value, so it wins over MEM; a load in EX has nothing to give yet
            if (uses_Rn_ID && w_mex_rn && !r_ex_ld) begin
                fwdA_sel = LP_FWD_EX;
            end else if (uses_Rn_ID && w_mmem_rn) begin
                fwdA_sel = LP_FWD_MEM;
            end
            if (uses_Rm_ID && w_mex_rm && !r_ex_ld) begin
                fwdB_sel = LP_FWD_EX;
            end else if (uses_Rm_ID && w_mmem_rm) begin
                fwdB_sel = LP_FWD_MEM;
            end
        end
    end

    // Track destination info alongside the real ID/EX and EX/MEM registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_dst  <= 5'd0;
            r_ex_rw   <= 1'b0;
            r_ex_ld   <= 1'b0;
            r_mem_dst <= 5'd0;
            r_mem_rw  <= 1'b0;
        end else begin
            r_mem_dst <= r_ex_dst;
            r_mem_rw  <= r_ex_rw;
            if (idex_bubble) begin
                r_ex_dst <= 5'd0;
                r_ex_rw  <= 1'b0;
                r_ex_ld  <= 1'b0;
            end else begin
                r_ex_dst <= WriteRegister_ID;
                r_ex_rw  <= RegWrite_ID;
                r_ex_ld  <= read_enable_ID;
            end
        end
    end

    // Branch flush sequencer: the branch cycle flushes once, FLUSH covers the remaining cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_fcnt  <= 3'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_br_go && LP_MULTI_FLSH) begin
                        r_state <= ST_FLUSH;
                        r_fcnt  <= LP_FCNT_INIT;
                    end
                end
                ST_FLUSH: begin
                    if (r_fcnt <= 3'd1) begin
                        r_state <= ST_RUN;
                        r_fcnt  <= 3'd0;
                    end else begin
                        r_fcnt  <= r_fcnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_fcnt  <= 3'd0;
                end
            endcase
        end
    end

    // Free-running wrap-around performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_ld_haz) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_now) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
